// File: rtl/if_id_queue_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : if_id_queue_if
//  Purpose  : Handshake bundle between the IF stage, the IF/ID instruction
//             queue and the ID stage. The master side is the IF/ID pipeline
//             environment (drives fetch data and the ID consume strobe); the
//             slave side is the queue itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) ();
    logic              in_valid;
    logic [ADDR_W-1:0] in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst
    );
endinterface
`default_nettype wire

// File: rtl/if_id_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : if_id_queue
//  Purpose  : DEPTH-entry FIFO between IF and ID with valid/ready handshakes,
//             global rdy freeze and single-cycle flush. An empty queue shows
//             a zero bubble on out_pc/out_inst.
//  Options  : IFQ_BYPASS_EN - when defined, an empty queue forwards the
//             incoming fetch combinationally to the output in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              rdy,
    input  wire logic              flush,
    if_id_queue_if.slave           bus,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]   c_DEPTH_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  r_mem_pc   [DEPTH];
    logic [INST_W-1:0]  r_mem_inst [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_store;
    logic w_advance_rd;

    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_empty = (r_count == '0);

`ifdef IFQ_BYPASS_EN
    // Empty queue forwards the fetch straight through; flush kills it.
    assign w_bypass = w_empty && bus.in_valid && rdy && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // in_ready depends only on registered state so it never waits on ID.
    assign bus.in_ready  = !w_full && rdy;
    assign bus.out_valid = (!w_empty && rdy) || w_bypass;

    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = bus.out_valid && bus.out_ready;

    // A bypassed word consumed in the same cycle is never written.
    assign w_store      = w_push && !(w_bypass && bus.out_ready);
    assign w_advance_rd = w_pop && !w_bypass;

    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;

    // Head presentation: bypass data, stored head, or the zero bubble.
    always_comb begin
        bus.out_pc   = '0;
        bus.out_inst = '0;
        if (w_bypass) begin
            bus.out_pc   = bus.in_pc;
            bus.out_inst = bus.in_inst;
        end else if (bus.out_valid) begin
            bus.out_pc   = r_mem_pc[r_rd_ptr];
            bus.out_inst = r_mem_inst[r_rd_ptr];
        end
    end

    // Storage array: written on accepted pushes, intentionally not reset.
    always_ff @(posedge clk) begin
        if (rdy && !flush && w_store) begin
            r_mem_pc[r_wr_ptr]   <= bus.in_pc;
            r_mem_inst[r_wr_ptr] <= bus.in_inst;
        end
    end

    // Pointer and occupancy update: freeze, then flush, then push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_store) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_advance_rd) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_store, w_advance_rd})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_queue
//  Purpose  : Self-checking bench for if_id_queue (DEPTH=4). Directed stimulus
//             feeds a scoreboard; a negedge monitor checks handshakes,
//             occupancy and head data against an independent queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       flush;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int errors = 0;
    int checks = 0;

    ent_t sb[$];

    if_id_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

    if_id_queue #(
        .ADDR_W(32),
        .INST_W(32),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rdy  (rdy),
        .flush(flush),
        .bus  (bus),
        .count(count),
        .full (full),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard monitor: model the queue and check the DUT every cycle.
    always @(negedge clk) begin
        int   m_cnt;
        logic m_in_ready;
        logic m_out_valid;
        logic m_byp;
        ent_t e;
        if (rst) begin
            sb.delete();
        end else begin
            m_cnt      = sb.size();
            m_in_ready = (m_cnt < DEPTH) && rdy;
            m_byp      = 1'b0;
`ifdef IFQ_BYPASS_EN
            m_byp      = (m_cnt == 0) && bus.in_valid && rdy && !flush;
`endif
            m_out_valid = ((m_cnt != 0) && rdy) || m_byp;
            chk("mon_count", 32'(count), 32'(m_cnt));
            chk("mon_full", 32'(full), 32'(m_cnt == DEPTH));
            chk("mon_empty", 32'(empty), 32'(m_cnt == 0));
            chk("mon_in_ready", 32'(bus.in_ready), 32'(m_in_ready));
            chk("mon_out_valid", 32'(bus.out_valid), 32'(m_out_valid));
            if (!m_out_valid) begin
                chk("mon_bubble_pc", bus.out_pc, 32'h0);
                chk("mon_bubble_inst", bus.out_inst, 32'h0);
            end
            if (rdy) begin
                if (flush) begin
                    sb.delete();
                end else begin
                    if (bus.in_valid && m_in_ready) begin
                        sb.push_back('{pc: bus.in_pc, inst: bus.in_inst});
                    end
                    if (m_out_valid && bus.out_ready) begin
                        if (sb.size() == 0) begin
                            chk("mon_unexpected_pop", 32'(bus.out_valid), 32'h0);
                        end else begin
                            e = sb.pop_front();
                            chk("mon_pc", bus.out_pc, e.pc);
                            chk("mon_inst", bus.out_inst, e.inst);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        rdy           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        step();
        rst = 1'b0;
        step();

        // Fill and drain
        for (int i = 0; i < 4; i++) push_one(32'(4 * i), 32'hA1 + 32'(i));
        @(negedge clk);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fill_head_inst", bus.out_inst, 32'hA1);
        push_one(32'hDEAD, 32'hBAD);
        @(negedge clk);
        chk("full_block_count", 32'(count), 32'd4);
        step();
        bus.out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        bus.out_ready = 1'b0;

        // Wrap-around with simultaneous push/pop at count=2
        for (int k = 0; k < 10; k++) begin
            bus.in_valid  = 1'b1;
            bus.in_pc     = 32'h200 + 32'(4 * k);
            bus.in_inst   = 32'hB00 + 32'(k);
            bus.out_ready = (k >= 2);
            @(negedge clk);
            if (k >= 2) chk("wrap_count", 32'(count), 32'd2);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("wrap_empty", 32'(empty), 32'd1);
        step();
        bus.out_ready = 1'b0;

        // Flush with same-cycle push and pop
        for (int i = 0; i < 3; i++) push_one(32'h300 + 32'(4 * i), 32'hC0 + 32'(i));
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h100;
        bus.in_inst   = 32'hDEADBEEF;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_pre_count", 32'(count), 32'd3);
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_out_pc", bus.out_pc, 32'h0);
        repeat (3) step();
        bus.out_ready = 1'b0;

        // rdy freeze
        push_one(32'h400, 32'hD0);
        push_one(32'h404, 32'hD1);
        rdy           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h500;
        bus.in_inst   = 32'hD5;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("frz_in_ready", 32'(bus.in_ready), 32'd0);
            chk("frz_out_valid", 32'(bus.out_valid), 32'd0);
            chk("frz_count", 32'(count), 32'd2);
            step();
        end
        rdy          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("frz_head_pc", bus.out_pc, 32'h400);
        repeat (2) step();
        @(negedge clk);
        chk("frz_drain_empty", 32'(empty), 32'd1);
        step();

        // Same-cycle bypass versus one-cycle latency
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h40;
        bus.in_inst   = 32'h00000013;
        bus.out_ready = 1'b1;
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        chk("byp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("byp_out_pc", bus.out_pc, 32'h40);
        chk("byp_out_inst", bus.out_inst, 32'h13);
        chk("byp_count", 32'(count), 32'd0);
`else
        chk("lat_out_valid0", 32'(bus.out_valid), 32'd0);
`endif
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        chk("byp_next_valid", 32'(bus.out_valid), 32'd0);
        chk("byp_next_count", 32'(count), 32'd0);
`else
        chk("lat_out_valid1", 32'(bus.out_valid), 32'd1);
        chk("lat_out_pc", bus.out_pc, 32'h40);
        chk("lat_count", 32'(count), 32'd1);
`endif
        step();
        @(negedge clk);
        chk("lat_end_empty", 32'(empty), 32'd1);
        step();
        bus.out_ready = 1'b0;

        // Asynchronous reset mid-cycle with count=3
        for (int i = 0; i < 3; i++) push_one(32'h600 + 32'(4 * i), 32'hE0 + 32'(i));
        @(negedge clk);
        chk("arst_pre_count", 32'(count), 32'd3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_pc", bus.out_pc, 32'h0);
        chk("arst_out_inst", bus.out_inst, 32'h0);
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline latch: a DEPTH-entry instruction buffer between the IF and ID stages.
- Decouples fetch from decode through valid/ready handshakes on both sides, so IF can run ahead while ID stalls.
- Supports a global rdy freeze and a single-cycle flush for branch/jump redirect.
- Empty-queue output is a ZeroWord bubble, as the old latch produced.

Parameters:
- ADDR_W, 32, width of instruction address (pc).
- INST_W, 32, width of instruction word.
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of occupancy count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- rdy  in  1  global ready; low freezes all state.
- flush  in  1  discard all entries (redirect from EX).
- in_valid  in  1  IF presents pc/inst.
- in_pc  in  ADDR_W  fetched pc.
- in_inst  in  INST_W  fetched instruction.
- in_ready  out  1  queue can accept this cycle.
- out_valid  out  1  head entry valid.
- out_pc  out  ADDR_W  head pc; zero when not valid.
- out_inst  out  INST_W  head instruction; zero when not valid.
- out_ready  in  1  ID consumes head (ID not stalled).
- count  out  CNT_W  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset, asynchronous: rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, out_valid=0, out_pc=0, out_inst=0, in_ready=1. Storage array is not reset.
- Outputs derived from registered state only:
  - in_ready = !full && rdy.
  - out_valid = !empty && rdy.
  - out_pc/out_inst = mem[rd_ptr] when out_valid, else 0.
- push = in_valid && in_ready.
- pop = out_valid && out_ready.
- On each clock edge, priority order:
  - rdy=0: no state change; push/pop ignored.
  - flush=1: pointers and count to 0; any same-cycle push or pop is discarded. out_valid is 0 in the following cycle.
  - Otherwise:
    - push writes mem[wr_ptr] and increments wr_ptr.
    - pop increments rd_ptr.
    - count += push - pop.
- Simultaneous push and pop:
  - Non-empty: count unchanged, both pointers advance.
  - Full: push is blocked by in_ready=0, so count goes DEPTH to DEPTH-1. No same-cycle full-pass-through, to keep in_ready free of out_ready.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Latency, default build: a push at edge N makes out_valid=1 in the cycle after edge N, provided no flush occurs. A pushed word reaches ID no earlier than one cycle after fetch, matching the old latch.
- Ordering is strictly FIFO. No entry is duplicated or dropped, except by flush.
- Reset asserted mid-operation clears everything immediately, regardless of clk or rdy.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When the queue is empty, in_valid=1 and rdy=1, out_valid=1 combinationally and out_pc/out_inst = in_pc/in_inst in the same cycle.
  - If out_ready=1 in that cycle, the word is consumed without being written: count stays 0 and pointers do not move.
  - flush=1 suppresses the bypass (out_valid=0).
- Undefined: no combinational in-to-out path; latency is exactly as stated in Behaviour.

Test Plan:
1. Reset then idle: assert rst mid-cycle with count=3 -> immediately count=0, empty=1, out_valid=0, out_pc=0, out_inst=0.
2. Fill and drain, DEPTH=4: push pc 0x0,0x4,0x8,0xC with inst 0xA1..0xA4 and out_ready=0 -> full=1, in_ready=0. Then hold out_ready=1 -> pops 0x0,0x4,0x8,0xC in order, then empty=1.
3. Wrap-around: perform 10 pushes and 10 pops interleaved with simultaneous push/pop when count=2 -> count stays 2 on those cycles, outputs in order with no loss across the pointer wrap.
4. Flush: count=3, flush=1 with in_valid=1 (pc 0x100) and out_ready=1 -> next cycle count=0, out_valid=0, and 0x100 is never output.
5. rdy freeze: count=2, rdy=0 for 3 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, count stays 2. After rdy returns to 1 -> the same head pc is output.
6. IFQ_BYPASS_EN: empty queue, in_valid=1 (pc 0x40, inst 0x00000013), out_ready=1 -> same cycle out_valid=1, out_pc=0x40; count stays 0. Without the macro -> out_valid=0 that cycle, 1 the next cycle.
